// File: rtl/md_unit_ctrl.sv
// ============================================================================
// Module      : md_unit_ctrl
// Description : EX-stage multiply/divide sequencer owning architectural HI/LO,
//               with fixed-latency busy counter and decode-stage stall request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    input  logic        MdInstr_D,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] phi_q,   phi_d;
    logic [31:0] plo_q,   plo_d;
    logic        dz_q,    dz_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic        w_issue;
    logic        w_signed;
    logic [63:0] w_mul_a, w_mul_b, w_prod;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_divisor;
    logic [31:0] w_uq, w_ur, w_quo, w_rem;

    // MULT/DIV are the even opcodes and are the signed variants.
    assign w_signed = ~Op[0];

    always_comb begin
        w_mul_a = {{32{w_signed & A[31]}}, A};
        w_mul_b = {{32{w_signed & B[31]}}, B};
        w_prod  = w_mul_a * w_mul_b;

        // Magnitude division sidesteps the signed-overflow case 0x80000000 / -1.
        w_a_neg   = w_signed & A[31];
        w_b_neg   = w_signed & B[31];
        w_a_mag   = w_a_neg ? (32'd0 - A) : A;
        w_b_mag   = w_b_neg ? (32'd0 - B) : B;
        w_divisor = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
        w_uq      = w_a_mag / w_divisor;
        w_ur      = w_a_mag % w_divisor;
        w_quo     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
        w_rem     = w_a_neg ? (32'd0 - w_ur) : w_ur;
    end

    assign w_issue = Start && !Flush && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (w_issue) begin
                    case (Op)
                        OP_MULT, OP_MULTU: begin
                            phi_d   = w_prod[63:32];
                            plo_d   = w_prod[31:0];
                            dz_d    = 1'b0;
                            cnt_d   = 4'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            phi_d   = w_rem;
                            plo_d   = w_quo;
                            dz_d    = (B == 32'd0);
                            cnt_d   = 4'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            default: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    // Divide-by-zero still burns the full latency but leaves HI/LO alone.
                    if (!dz_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy  = (state_q == S_RUN);
    assign Stall = MdInstr_D && (Busy || (Start && !Flush && (Op <= OP_DIVU)));
    assign HI    = hi_q;
    assign LO    = lo_q;

    // The hazard unit must hold off new md instructions while one is in flight.
    a_no_start_in_run: assert property (@(posedge Clk) disable iff (Reset)
        !(Start && (state_q == S_RUN)));

endmodule

`default_nettype wire

// File: tb/tb_md_unit_ctrl.sv
// ============================================================================
// Module      : tb_md_unit_ctrl
// Description : Self-checking bench for md_unit_ctrl (vector table, corner
//               sequences, randomized ops against an arithmetic model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Start, Flush, MdInstr_D;
    logic [2:0]  Op;
    logic [31:0] A, B;
    logic        Busy, Stall;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi, m_lo;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Flush(Flush), .MdInstr_D(MdInstr_D), .Busy(Busy), .Stall(Stall),
        .HI(HI), .LO(LO)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        flush;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: architectural effect of one instruction from the ISA rules.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic flush, output logic [31:0] nh, output logic [31:0] nl,
                         output int cyc);
        longint      sp, sq, sr;
        logic [63:0] up;
        nh = m_hi; nl = m_lo; cyc = 0;
        if (!flush) begin
            case (op)
                3'd0: begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    nh = sp[63:32]; nl = sp[31:0]; cyc = 5;
                end
                3'd1: begin
                    up = {32'd0, a} * {32'd0, b};
                    nh = up[63:32]; nl = up[31:0]; cyc = 5;
                end
                3'd2: begin
                    cyc = 10;
                    if (b != 0) begin
                        sq = longint'($signed(a)) / longint'($signed(b));
                        sr = longint'($signed(a)) % longint'($signed(b));
                        nl = sq[31:0]; nh = sr[31:0];
                    end
                end
                3'd3: begin
                    cyc = 10;
                    if (b != 0) begin
                        nl = a / b; nh = a % b;
                    end
                end
                3'd4: nh = a;
                3'd5: nl = a;
                default: ;
            endcase
        end
    endtask

    // Issue one instruction, watch Busy/Stall through completion, then check HI/LO.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic flush, input logic md,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_cyc);
        int cyc;
        int stall_bad;
        int hold_bad;
        logic [31:0] pre_hi, pre_lo;
        @(negedge Clk);
        pre_hi = HI; pre_lo = LO;
        Start = 1'b1; Op = op; A = a; B = b; Flush = flush; MdInstr_D = md;
        #1;
        check({name, ".stall_issue"}, {31'd0, Stall}, {31'd0, md && !flush && (op <= 3'd3)});
        @(negedge Clk);
        Start = 1'b0; Flush = 1'b0;
        cyc = 0; stall_bad = 0; hold_bad = 0;
        while (Busy && cyc < 40) begin
            if (Stall !== md) stall_bad++;
            if (HI !== pre_hi || LO !== pre_lo) hold_bad++;
            cyc++;
            @(negedge Clk);
        end
        check({name, ".busy_cycles"}, cyc, exp_cyc);
        check({name, ".stall_busy"}, stall_bad, 0);
        check({name, ".hilo_hold"}, hold_bad, 0);
        check({name, ".stall_after"}, {31'd0, Stall}, 32'd0);
        check({name, ".hi"}, HI, exp_hi);
        check({name, ".lo"}, LO, exp_lo);
        m_hi = exp_hi; m_lo = exp_lo;
    endtask

    vec_t vecs[11];

    initial begin
        logic [31:0] nh, nl;
        int          cyc, ncyc;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic        rfl, rmd;

        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,          1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3,          1'b0, 32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,          1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{3'd3, 32'd7,        32'd2,          1'b0, 32'h00000001, 32'h00000003, 10};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF,   1'b0, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{3'd4, 32'h00000011, 32'd0,          1'b0, 32'h00000011, 32'h80000000, 0};
        vecs[6]  = '{3'd5, 32'h00000022, 32'd0,          1'b0, 32'h00000011, 32'h00000022, 0};
        vecs[7]  = '{3'd3, 32'h12345678, 32'd0,          1'b0, 32'h00000011, 32'h00000022, 10};
        vecs[8]  = '{3'd0, 32'h00001234, 32'h00005678,   1'b1, 32'h00000011, 32'h00000022, 0};
        vecs[9]  = '{3'd4, 32'h0000DEAD, 32'd0,          1'b1, 32'h00000011, 32'h00000022, 0};
        vecs[10] = '{3'd6, 32'hCAFEF00D, 32'h00000001,   1'b0, 32'h00000011, 32'h00000022, 0};

        Reset = 1'b1; Start = 1'b0; Flush = 1'b0; MdInstr_D = 1'b0;
        Op = 3'd0; A = 32'd0; B = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("reset.busy", {31'd0, Busy}, 32'd0);
        check("reset.hi", HI, 32'd0);
        check("reset.lo", LO, 32'd0);

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].flush,
                   1'b1, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_cyc);

        // Flush pulsed in RUN cycle 3 must not cancel the in-flight MULT.
        @(negedge Clk);
        Start = 1'b1; Op = 3'd0; A = 32'd5; B = 32'd7; MdInstr_D = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        ncyc = 0;
        while (Busy && ncyc < 40) begin
            ncyc++;
            Flush = (ncyc == 3);
            @(negedge Clk);
        end
        Flush = 1'b0;
        check("flush_run.busy_cycles", ncyc, 5);
        check("flush_run.hi", HI, 32'd0);
        check("flush_run.lo", LO, 32'd35);
        m_hi = 32'd0; m_lo = 32'd35;

        // Reset in RUN cycle 4 of a DIV aborts it; no late commit.
        run_op("preload_hi", 3'd4, 32'hAAAA5555, 32'd0, 1'b0, 1'b0, 32'hAAAA5555, 32'd35, 0);
        @(negedge Clk);
        Start = 1'b1; Op = 3'd2; A = 32'd100; B = 32'd7; MdInstr_D = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_div.busy_c4", {31'd0, Busy}, 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("rst_div.busy", {31'd0, Busy}, 32'd0);
        check("rst_div.hi", HI, 32'd0);
        check("rst_div.lo", LO, 32'd0);
        repeat (15) @(negedge Clk);
        check("rst_div.no_commit_hi", HI, 32'd0);
        check("rst_div.no_commit_lo", LO, 32'd0);
        check("rst_div.idle", {31'd0, Busy}, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            rfl = ($urandom_range(0, 7) == 0);
            rmd = 1'($urandom_range(0, 1));
            model(rop, ra, rb, rfl, nh, nl, cyc);
            run_op($sformatf("rnd%0d", i), rop, ra, rb, rfl, rmd, nh, nl, cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
